// File: rtl/req_ack_monitor.sv
// req_ack_monitor: per-channel req/ack latency checker with pass/fail/abort/cover statistics
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   en, clr          monitor enable and synchronous counter clear
//   req, ack, abort  per-channel request, acknowledge and accept-on condition
//   pending          channel has an open attempt
//   fail, cover_hit  one-cycle pulses on timeout and on a req ##1 ack match
//   *_cnt            saturating event counters summed over all channels
module req_ack_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MAX_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ack,
    input  logic [NUM_CH-1:0] abort,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] fail,
    output logic [NUM_CH-1:0] cover_hit,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  abort_cnt,
    output logic [CNT_W-1:0]  cover_cnt
);
    localparam int KW = $clog2(MAX_LAT + 1);
    localparam int SW = CNT_W + 6;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state   [NUM_CH];
    state_t            state_n [NUM_CH];
    logic   [KW-1:0]   k       [NUM_CH];
    logic   [KW-1:0]   k_n     [NUM_CH];
    logic [NUM_CH-1:0] prev_req;
    logic [NUM_CH-1:0] ev_pass, ev_fail, ev_abort, ev_cover, done, restart;

    // Adds every event bit of one kind at once, clamping at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [NUM_CH-1:0] ev);
        logic [SW-1:0] s;
        s = SW'(c);
        for (int i = 0; i < NUM_CH; i++) s = s + SW'(ev[i]);
        return (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign ev_cover = ack & prev_req;
    assign restart  = req & ~abort;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ev_abort[i] = abort[i] & (req[i] | state[i] == WAIT);
            ev_pass[i]  = state[i] == WAIT && !abort[i] && ack[i];
            ev_fail[i]  = state[i] == WAIT && !abort[i] && !ack[i] && k[i] == KW'(MAX_LAT);
            done[i]     = state[i] == IDLE || ev_abort[i] || ev_pass[i] || ev_fail[i];
            // A resolving edge doubles as a request-sampling edge; otherwise req is ignored in WAIT.
            state_n[i]  = done[i] ? (restart[i] ? WAIT : IDLE) : WAIT;
            k_n[i]      = done[i] ? (restart[i] ? KW'(1) : KW'(0)) : k[i] + KW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                k[i]     <= '0;
            end
            prev_req  <= '0;
            pending   <= '0;
            fail      <= '0;
            cover_hit <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            abort_cnt <= '0;
            cover_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]   <= en ? state_n[i] : IDLE;
                k[i]       <= en ? k_n[i] : '0;
                pending[i] <= en && state_n[i] == WAIT;
            end
            prev_req  <= en ? req : '0;
            fail      <= en ? ev_fail : '0;
            cover_hit <= en ? ev_cover : '0;
            if (clr) begin
                pass_cnt  <= '0;
                fail_cnt  <= '0;
                abort_cnt <= '0;
                cover_cnt <= '0;
            end else if (en) begin
                pass_cnt  <= sat_add(pass_cnt, ev_pass);
                fail_cnt  <= sat_add(fail_cnt, ev_fail);
                abort_cnt <= sat_add(abort_cnt, ev_abort);
                cover_cnt <= sat_add(cover_cnt, ev_cover);
            end
        end
    end
endmodule

// File: tb/tb_req_ack_monitor.sv
// tb_req_ack_monitor: scoreboard bench for req_ack_monitor (2 channels, MAX_LAT=3, CNT_W=16 and CNT_W=2)
module tb_req_ack_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  req = '0, ack = '0, abort = '0;
    logic [1:0]  pending, fail, cover_hit;
    logic [15:0] pass_cnt, fail_cnt, abort_cnt, cover_cnt;
    logic [1:0]  s_pending, s_fail, s_cover_hit;
    logic [1:0]  s_pass_cnt, s_fail_cnt, s_abort_cnt, s_cover_cnt;
    logic [71:0] obs;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  req, ack, abort;
        logic        en, clr;
        logic [71:0] exp;
    } row_t;

    typedef struct {
        string       name;
        int          step;
        logic [71:0] exp;
    } sb_t;

    sb_t sb[$];

    req_ack_monitor #(.NUM_CH(2), .MAX_LAT(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .ack(ack), .abort(abort),
        .pending(pending), .fail(fail), .cover_hit(cover_hit), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .abort_cnt(abort_cnt), .cover_cnt(cover_cnt)
    );

    req_ack_monitor #(.NUM_CH(2), .MAX_LAT(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .ack(ack), .abort(abort),
        .pending(s_pending), .fail(s_fail), .cover_hit(s_cover_hit), .pass_cnt(s_pass_cnt),
        .fail_cnt(s_fail_cnt), .abort_cnt(s_abort_cnt), .cover_cnt(s_cover_cnt)
    );

    // Fields: pending, fail, cover_hit, pass, fail, abort, cover counts, then fail_cnt of the 2-bit instance.
    assign obs = {pending, fail, cover_hit, pass_cnt, fail_cnt, abort_cnt, cover_cnt, s_fail_cnt};

    always #5 clk = ~clk;

    function automatic row_t mk_row(input logic [1:0] rq, ak, ab, input logic e, c,
                                    input logic [1:0] pd, fl, cv, input int pc, fc, ac, cc, sfc);
        row_t r;
        r.req = rq; r.ack = ak; r.abort = ab; r.en = e; r.clr = c;
        r.exp = {pd, fl, cv, 16'(pc), 16'(fc), 16'(ac), 16'(cc), 2'(sfc)};
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (obs !== 72'd0) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs, 72'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"pass", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    task automatic test_timeout();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b01, 2'b00, 0, 1, 0, 0, 1));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 1));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"timeout", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    task automatic test_abort();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b01, 2'b01, 1, 0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 1, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2, 1, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2, 1, 0));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"abort", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    task automatic test_cover();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b10, 2'b00, 2'b00, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b10, 2'b00, 2'b00, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b10, 2'b00, 2'b00, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b10, 2'b00, 1, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0, 1, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"cover", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 2'b01, 1, 0, 0, 1, 0));
        r.push_back(mk_row(2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 2'b01, 2, 0, 0, 2, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2, 0, 0, 2, 0));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"back_to_back", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    task automatic test_sat_fail();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b11, 2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b11, 2'b00, 0, 2, 0, 0, 2));
        r.push_back(mk_row(2'b11, 2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 0, 2, 0, 0, 2));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 0, 2, 0, 0, 2));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 0, 2, 0, 0, 2));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b11, 2'b00, 0, 4, 0, 0, 3));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 4, 0, 0, 3));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 4, 0, 0, 3));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 4, 0, 0, 3));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b01, 2'b00, 0, 5, 0, 0, 3));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 5, 0, 0, 3));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"sat_fail", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    task automatic test_enable_clr();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b01, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"enable_clr", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    task automatic test_rst_mid();
        row_t r[$];
        sb_t  e;
        r.push_back(mk_row(2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        r.push_back(mk_row(2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0, 1, 0));
        r.push_back(mk_row(2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1, 0));
        foreach (r[i]) begin
            req = r[i].req; ack = r[i].ack; abort = r[i].abort; en = r[i].en; clr = r[i].clr;
            sb.push_back('{"rst_mid_pre", i, r[i].exp});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
        req = 2'b00;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 72'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got %h want %h", obs, 72'd0);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{"rst_mid_post", i, 72'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, e.step, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pass();
        test_timeout();
        test_abort();
        test_cover();
        test_back_to_back();
        test_sat_fail();
        test_enable_clr();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/req_ack_monitor.md
REQ_ACK_MONITOR -- requirements
Module: req_ack_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent req/ack channels (1..32).
REQ-002 SHALL have parameter MAX_LAT, default 1, meaning the last edge after the request edge at which ack is still accepted (1..255); MAX_LAT=1 is strict next-cycle acknowledge.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter (2..32).
REQ-004 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  monitor enable.
- clr  in  1  synchronous clear of all counters.
- req  in  NUM_CH  per-channel request.
- ack  in  NUM_CH  per-channel acknowledge.
- abort  in  NUM_CH  per-channel accept-on condition.
- pending  out  NUM_CH  channel has an open attempt.
- fail  out  NUM_CH  one-cycle pulse on timeout.
- cover_hit  out  NUM_CH  one-cycle pulse on a cover match.
- pass_cnt  out  CNT_W  attempts passed by ack.
- fail_cnt  out  CNT_W  attempts failed by timeout.
- abort_cnt  out  CNT_W  attempts accepted by abort.
- cover_cnt  out  CNT_W  cover matches.
REQ-005 SHALL register every output; no combinational path from inputs to outputs.

Function
REQ-006 SHALL implement one two-state FSM per channel, IDLE and WAIT, plus a latency counter k (width clog2(MAX_LAT+1)).
REQ-007 SHALL, in IDLE at an edge with req=1 and abort=0, move the channel to WAIT with k=1.
REQ-008 SHALL, in IDLE at an edge with req=1 and abort=1, count one abort and stay in IDLE.
REQ-009 SHALL, in WAIT, resolve the attempt by priority: abort=1 counts an abort; otherwise ack=1 counts a pass; otherwise k==MAX_LAT counts a fail and pulses fail; otherwise k increments.
REQ-010 SHALL, on resolution with req=1 and abort=0 at the same edge, start a new attempt (stay in WAIT, k=1); on any other resolution, go to IDLE.
REQ-011 SHALL ignore req in WAIT unless that edge resolves the attempt; only one attempt per channel is open at a time.
REQ-012 SHALL drive pending=1 exactly while the channel is in WAIT.
REQ-013 SHALL pulse cover_hit when ack=1 at edge t and req=1 at edge t-1 (sequence req[*1:$] ##1 ack), independent of FSM state, using a per-channel registered prev_req.
REQ-014 SHALL add the number of events of each kind across all channels at a given edge to its counter in one edge, so up to NUM_CH increments per edge.
REQ-015 SHALL saturate every counter at 2^CNT_W-1; no wrap-around.
REQ-016 SHALL, with clr=1, load all counters with 0 at that edge; clr overrides same-edge increments; FSMs are unaffected.
REQ-017 SHALL, with en=0 at an edge, force all channels to IDLE, clear prev_req, drive fail and cover_hit to 0, and hold the counters (clr still acts); an open attempt is dropped without being counted.
REQ-018 SHALL keep the channels fully independent; simultaneous events on several channels are all counted.

Reset
REQ-019 SHALL, while rst=1, asynchronously force all FSMs to IDLE, k to 0, prev_req to 0, and pending, fail, cover_hit and all counters to 0.
REQ-020 SHALL drop any attempt open at reset assertion without counting it; after rst deasserts, the first edge with en=1 is a valid request-sampling edge.

Verification (NUM_CH=2, MAX_LAT=3, CNT_W=16 unless stated)
REQ-021 SHALL check: req[0] high for edge E0 only, ack[0] high at E2 -> pending[0] 1 after E0 and 0 after E2; pass_cnt=1; fail never pulses.
REQ-022 SHALL check: req[0] at E0, no ack -> fail[0] pulses for exactly one cycle after E3; fail_cnt=1; pending[0]=0.
REQ-023 SHALL check: req[0] at E0, abort[0] and ack[0] both high at E1 -> abort_cnt=1, pass_cnt=0; req[0]=abort[0]=1 in IDLE -> abort_cnt increments and pending stays 0.
REQ-024 SHALL check: req[1] high E0..E2, ack[1] at E3 -> one cover_hit[1] pulse after E3, cover_cnt=1; req[1] also resolved as pass.
REQ-025 SHALL check: both channels time out at the same edge -> fail=2'b11 and fail_cnt advances by 2; with CNT_W=2, five timeouts -> fail_cnt=3.
REQ-026 SHALL check: rst asserted mid-WAIT without a clock edge -> pending=0 and all counters 0 immediately; no fail pulse after release.
